// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, mode, ULA and RDM-source codes plus strobe-word helpers for control_sequencer
package ctrl_pkg;
    localparam int T_MIN = 10;
    localparam int OP_NOP = 0, OP_STA = 1, OP_LDA = 2, OP_ADD = 3, OP_SUB = 4, OP_AND = 5,
                   OP_OR = 6, OP_NOT = 7, OP_J = 8, OP_JN = 9, OP_JZ = 10, OP_IN = 11,
                   OP_OUT = 12, OP_SHR = 13, OP_SHL = 14, OP_HLT = 15;
    localparam logic [1:0] MODE_DIR = 2'b00, MODE_IND = 2'b01, MODE_IM = 2'b10;
    localparam logic [1:0] RDM_MEM = 2'b00, RDM_AC = 2'b01, RDM_IN = 2'b10;
    typedef enum logic [2:0] {
        ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_NOT, ULA_SHR, ULA_SHL, ULA_PASSB
    } ulaOp_t;
    typedef struct packed {
        logic writeAc, writePc, writeN, writeZ, writeMem, writeRdm, writeRi, writeOut, writeRem;
        logic selRem, incPc;
        logic [1:0] selRdm;
        ulaOp_t opUla;
    } ctrlWord_t;
    function automatic ulaOp_t ulaFor(input int op);
        return op == OP_ADD ? ULA_ADD : op == OP_SUB ? ULA_SUB : op == OP_AND ? ULA_AND :
               op == OP_OR  ? ULA_OR  : op == OP_NOT ? ULA_NOT : op == OP_SHR ? ULA_SHR :
               op == OP_SHL ? ULA_SHL : ULA_PASSB;
    endfunction
    function automatic ctrlWord_t execWord(input ulaOp_t u);
        ctrlWord_t w;
        w = '0;
        w.writeAc = 1'b1;
        w.writeN = 1'b1;
        w.writeZ = 1'b1;
        w.opUla = u;
        return w;
    endfunction
    // Final step of a memory-operand instruction: STA stores, everything else loads AC/N/Z.
    function automatic ctrlWord_t memExec(input int op);
        ctrlWord_t w;
        w = '0;
        w.writeMem = 1'b1;
        return op == OP_STA ? w : execWord(ulaFor(op));
    endfunction
endpackage

// File: rtl/control_sequencer_step_counter.sv
// step_counter: one-hot rotating step vector with hold and clear-to-T0
module step_counter #(
    parameter int NUM_T = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [NUM_T-1:0] tState
);
    always_ff @(posedge clk)
        if (rst || clear) tState <= NUM_T'(1);
        else if (advance) tState <= {tState[NUM_T-2:0], tState[NUM_T-1]};
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: step counter + opcode/mode/flag decode into datapath strobes
// CTRL_SINGLE_STEP_EN: when defined, steps advance only in cycles with step=1.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int NUM_T = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [1:0]       mode,
    input  logic             flag_n,
    input  logic             flag_z,
    input  logic             mem_rdy,
    input  logic             step,
    output logic             write_ac,
    output logic             write_pc,
    output logic             write_n,
    output logic             write_z,
    output logic             write_mem,
    output logic             write_rdm,
    output logic             write_ri,
    output logic             write_out,
    output logic             write_rem,
    output logic             sel_rem,
    output logic             inc_pc,
    output logic [1:0]       sel_rdm,
    output logic [2:0]       op_ula,
    output logic             mem_req,
    output logic [NUM_T-1:0] t_state,
    output logic             halted
);
    if (NUM_T < T_MIN) begin : gBadNumT
        $error("control_sequencer: NUM_T must be at least T_MIN");
    end
    int op;
    logic isSta, operand, jump, jCond, last, halt, memStep, adv;
    ctrlWord_t cw, word;
    assign op = int'(opcode);
    assign isSta = op == OP_STA;
    assign operand = op >= OP_STA && op <= OP_OR && mode != 2'b11;
    assign jCond = op == OP_JN || op == OP_JZ;
    assign jump = op == OP_J || (op == OP_JN && flag_n) || (op == OP_JZ && flag_z);
    always_comb begin
        cw = '0;
        last = 1'b0;
        halt = 1'b0;
        if (t_state[0]) cw.writeRem = 1'b1;
        if (t_state[1]) begin
            cw.writeRdm = 1'b1;
            cw.incPc = 1'b1;
        end
        if (t_state[2]) cw.writeRi = 1'b1;
        if (t_state[3]) begin
            if (op == OP_HLT) halt = 1'b1;
            else if (operand || jump) cw.writeRem = 1'b1;
            else if (jCond) begin
                cw.incPc = 1'b1;
                last = 1'b1;
            end else if (op == OP_NOT || op == OP_SHR || op == OP_SHL) begin
                cw = execWord(ulaFor(op));
                last = 1'b1;
            end else if (op == OP_IN) begin
                cw.writeRdm = 1'b1;
                cw.selRdm = RDM_IN;
            end else begin
                cw.writeOut = op == OP_OUT;
                last = 1'b1;
            end
        end
        if (t_state[4]) begin
            if (operand || jump) begin
                cw.writeRdm = 1'b1;
                cw.incPc = 1'b1;
                last = isSta && mode == MODE_IM;
            end else begin
                cw = execWord(ULA_PASSB);
                last = 1'b1;
            end
        end
        if (t_state[5]) begin
            if (jump) begin
                cw.writePc = 1'b1;
                last = 1'b1;
            end else if (mode == MODE_IM) begin
                cw = execWord(ulaFor(op));
                last = 1'b1;
            end else begin
                cw.writeRem = 1'b1;
                cw.selRem = 1'b1;
            end
        end
        if (t_state[6]) begin
            cw.writeRdm = 1'b1;
            cw.selRdm = isSta && mode == MODE_DIR ? RDM_AC : RDM_MEM;
        end
        if (t_state[7]) begin
            if (mode == MODE_DIR) begin
                cw = memExec(op);
                last = 1'b1;
            end else begin
                cw.writeRem = 1'b1;
                cw.selRem = 1'b1;
            end
        end
        if (t_state[8]) begin
            cw.writeRdm = 1'b1;
            cw.selRdm = isSta ? RDM_AC : RDM_MEM;
        end
        if (t_state[9]) begin
            cw = memExec(op);
            last = 1'b1;
        end
        if (t_state[NUM_T-1]) last = 1'b1;
    end
    assign memStep = (cw.writeRdm && cw.selRdm == RDM_MEM) || cw.writeMem;
`ifdef CTRL_SINGLE_STEP_EN
    assign adv = (!memStep || mem_rdy) && step;
`else
    logic unusedStep;
    assign unusedStep = step;
    assign adv = !memStep || mem_rdy;
`endif
    assign word = !rst && !halted && adv && !halt ? cw : '0;
    assign mem_req = !rst && !halted && memStep;
    assign {write_ac, write_pc, write_n, write_z, write_mem, write_rdm, write_ri, write_out,
            write_rem, sel_rem, inc_pc, sel_rdm, op_ula} = word;
    always_ff @(posedge clk)
        if (rst) halted <= 1'b0;
        else if (halt && adv) halted <= 1'b1;
    step_counter #(.NUM_T(NUM_T)) uStepCounter (
        .clk(clk),
        .rst(rst),
        .clear(halted || (adv && (last || halt))),
        .advance(adv),
        .tState(t_state)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer with per-cycle expected strobe words
module tb_control_sequencer;
    localparam logic [16:0] AC = 17'h10000, PC = 17'h08000, NF = 17'h04000, ZF = 17'h02000,
                            MEM = 17'h01000, RDM = 17'h00800, RI = 17'h00400, OUT = 17'h00200,
                            REM = 17'h00100, SREM = 17'h00080, INC = 17'h00040, MREQ = 17'h00001;
    localparam logic [16:0] NZ = AC | NF | ZF;
    localparam logic [16:0] RDM_MEM = RDM | MREQ;
    localparam logic [16:0] FETCH_OP = RDM | INC | MREQ;
    typedef struct {
        int t;
        logic [16:0] s;
        logic h;
    } expT;
    logic clk = 0, rst = 1, flag_n = 0, flag_z = 0, mem_rdy = 1, step = 0;
    logic [3:0] opcode = 0;
    logic [1:0] mode = 0;
    logic write_ac, write_pc, write_n, write_z, write_mem, write_rdm, write_ri, write_out, write_rem;
    logic sel_rem, inc_pc, mem_req, halted;
    logic [1:0] sel_rdm;
    logic [2:0] op_ula;
    logic [9:0] t_state;
    expT sb[$];
    expT e;
    int checks = 0, errors = 0;

    control_sequencer #(.OPC_W(4), .NUM_T(10)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mode(mode), .flag_n(flag_n), .flag_z(flag_z),
        .mem_rdy(mem_rdy), .step(step), .write_ac(write_ac), .write_pc(write_pc),
        .write_n(write_n), .write_z(write_z), .write_mem(write_mem), .write_rdm(write_rdm),
        .write_ri(write_ri), .write_out(write_out), .write_rem(write_rem), .sel_rem(sel_rem),
        .inc_pc(inc_pc), .sel_rdm(sel_rdm), .op_ula(op_ula), .mem_req(mem_req),
        .t_state(t_state), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] opu(input int u);
        return 17'(u) << 1;
    endfunction

    function automatic logic [16:0] rsel(input int r);
        return 17'(r) << 4;
    endfunction

    task automatic cyc(input int t, input logic [16:0] s, input logic h = 0,
                       input logic rdy = 1, input logic r = 0);
        @(negedge clk);
        #1;
        mem_rdy = rdy;
        rst = r;
        sb.push_back('{t, s, h});
        #5;
    endtask

    task automatic fetch(input int opc, input logic [1:0] md);
        opcode = 4'(opc);
        mode = md;
        cyc(0, REM);
        cyc(1, FETCH_OP);
        cyc(2, RI);
    endtask

    always @(negedge clk) begin
        #4;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("T%0d t_state", e.t), 32'(t_state), 32'(1) << e.t);
            check($sformatf("T%0d strobes", e.t),
                  32'({write_ac, write_pc, write_n, write_z, write_mem, write_rdm, write_ri,
                       write_out, write_rem, sel_rem, inc_pc, sel_rdm, op_ula, mem_req}), 32'(e.s));
            check($sformatf("T%0d halted", e.t), 32'(halted), 32'(e.h));
        end
    end

    initial begin
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        // LDA direct
        fetch(2, 2'b00);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, REM | SREM); cyc(6, RDM_MEM); cyc(7, NZ | opu(7));
        // ADD indirect with two wait cycles on the T6 memory read
        fetch(3, 2'b01);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, REM | SREM);
        cyc(6, MREQ, 0, 0); cyc(6, MREQ, 0, 0); cyc(6, RDM_MEM);
        cyc(7, REM | SREM); cyc(8, RDM_MEM); cyc(9, NZ | opu(0));
        // JZ not taken, then taken
        flag_z = 0;
        fetch(10, 2'b00);
        cyc(3, INC);
        flag_z = 1;
        fetch(10, 2'b00);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, PC);
        // STA immediate is illegal, STA indirect stores at T9
        fetch(1, 2'b10);
        cyc(3, REM); cyc(4, FETCH_OP);
        fetch(1, 2'b01);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, REM | SREM); cyc(6, RDM_MEM);
        cyc(7, REM | SREM); cyc(8, RDM | rsel(1)); cyc(9, MEM | MREQ);
        // STA direct with one wait on the store
        fetch(1, 2'b00);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, REM | SREM); cyc(6, RDM | rsel(1));
        cyc(7, MREQ, 0, 0); cyc(7, MEM | MREQ);
        // SUB immediate, NOT, IN, OUT, NOP, illegal mode
        fetch(4, 2'b10);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, NZ | opu(1));
        fetch(7, 2'b00);
        cyc(3, NZ | opu(4));
        fetch(11, 2'b00);
        cyc(3, RDM | rsel(2)); cyc(4, NZ | opu(7));
        fetch(12, 2'b00);
        cyc(3, OUT);
        fetch(0, 2'b00);
        cyc(3, 0);
        fetch(5, 2'b11);
        cyc(3, 0);
        // reset in the middle of SUB direct
        fetch(4, 2'b00);
        cyc(3, REM); cyc(4, FETCH_OP); cyc(5, 0, 0, 1, 1);
        // HLT, then release with a one-cycle reset
        fetch(15, 2'b00);
        cyc(3, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, REM);
        cyc(1, FETCH_OP);
        repeat (4) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
